axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of read requesters (feature, weight, bias loaders).
REQ-002 Parameter ADDR_W, default 32: AXI address width.
REQ-003 Parameter DATA_W, default 512: AXI data width.
REQ-004 system_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_araddr  in  NUM_REQ*ADDR_W  per-requester burst address; requester i occupies slice i.
REQ-007 req_arlen  in  NUM_REQ*8  per-requester AXI burst length (beats-1).
REQ-008 req_arvalid  in  NUM_REQ  per-requester address request.
REQ-009 req_arready  out  NUM_REQ  per-requester address accept.
REQ-010 req_rdata  out  DATA_W  read data, broadcast to all requesters.
REQ-011 req_rlast  out  1  last beat, broadcast.
REQ-012 req_rvalid  out  NUM_REQ  data valid, asserted only for the granted requester.
REQ-013 req_rready  in  NUM_REQ  per-requester data ready.
REQ-014 m00_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  ADDR_W/8/3/2/1/4/3  shared AXI4 read address channel.
REQ-015 m00_axi_arvalid  out  1; m00_axi_arready  in  1.
REQ-016 m00_axi_rdata  in  DATA_W; m00_axi_rresp  in  2; m00_axi_rlast  in  1; m00_axi_rvalid  in  1; m00_axi_rready  out  1.
REQ-017 grant_id  out  clog2(NUM_REQ)  index of current owner; busy  out  1  high outside IDLE.
REQ-018 err_resp  out  1  sticky: any beat with rresp!=0; err_len  out  1  sticky: rlast position disagrees with latched arlen.

Function
REQ-019 States IDLE, ADDR, DATA; exactly one burst outstanding at any time.
REQ-020 IDLE: when any req_arvalid is high, register winner into grant_id, latch its araddr/arlen, go ADDR next cycle; latency req_arvalid to m00_axi_arvalid = 1 cycle.
REQ-021 ADDR: m00_axi_arvalid=1 with latched address/length; req_arready[grant_id]=m00_axi_arready combinationally; on arready go DATA.
REQ-022 Constant fields: arsize=3'b110, arburst=2'b01 (INCR), arlock=0, arcache=4'b0011, arprot=3'b000.
REQ-023 DATA: req_rvalid[grant_id]=m00_axi_rvalid, others 0; m00_axi_rready=req_rready[grant_id]; rdata/rlast pass through unregistered.
REQ-024 DATA: 8-bit beat counter increments per rvalid&rready handshake, cleared on entry to DATA.
REQ-025 Handshake with rlast=1 returns to IDLE next cycle; new grant possible in that IDLE cycle (minimum 1 idle cycle between bursts).
REQ-026 err_len set if rlast=1 when beat count != arlen, or beat count == arlen handshakes without rlast; burst still terminates only on rlast.
REQ-027 Requesters hold req_arvalid and address stable until req_arready; deasserting a non-granted request has no effect.
REQ-028 Non-granted requesters see req_arready=0 and req_rvalid=0 in all states.

Reset
REQ-029 rst_n low, at any time including mid-burst: state=IDLE, m00_axi_arvalid=0, m00_axi_rready=0, all req_arready/req_rvalid=0, grant_id=0, busy=0, beat counter=0, err_resp=0, err_len=0, round-robin pointer=0.
REQ-030 Error flags clear only on reset.

Configuration
REQ-031 Macro AXI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins.
REQ-032 Macro undefined: round-robin; search starts at index (last grant+1) mod NUM_REQ, pointer updated on burst completion.

Verification
REQ-033 Single req0, addr 0x1000, arlen 3, memory no stalls -> arvalid 1 cycle after request, 4 beats to req0 only, rlast on beat 4, err_len=0.
REQ-034 req0,req1,req2 all valid continuously, arlen 0, round-robin build -> grant order 0,1,2,0,1,2; fixed-priority build -> only 0 until req0 drops.
REQ-035 req1 rready toggled 1,0,1,0 during arlen 7 burst -> m00_axi_rready mirrors it, 8 beats delivered, no beats lost or duplicated.
REQ-036 Memory returns rlast on beat 2 of arlen 3 burst -> err_len=1, state back to IDLE; slave rresp=2'b10 on any beat -> err_resp=1 until reset.
REQ-037 rst_n pulsed low in DATA after beat 1 of 4 -> all outputs at reset values asynchronously; next req0 grants normally after release.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// Shared AXI4 read channel (AR + R) between the read arbiter and the memory slave.
// Latency: none, wires only.
// Backpressure: standard valid/ready on both the AR and R channels.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI4 read arbiter with one burst outstanding; round-robin, or fixed priority when AXI_ARB_FIXED_PRIO_EN is defined.
// Latency: req_arvalid -> m00_axi.arvalid 1 cycle; read data and rlast pass through combinationally.
// Backpressure: AR ready and R ready are forwarded combinationally to and from the granted requester only.
module axi_rd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  localparam int GNT_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_rlast,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  axi_rd_arbiter_if.master          m00_axi,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      err_resp,
  output logic                      err_len
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } ar_req_t;

  state_t             state;
  ar_req_t            ar_q;
  logic               arvalid_q;
  logic               busy_q;
  logic [7:0]         beat_cnt;
  logic [GNT_W-1:0]   win_idx;
  logic               rready_int;
  logic               r_hs;
  ar_req_t            req_arr [NUM_REQ];
`ifndef AXI_ARB_FIXED_PRIO_EN
  logic [GNT_W-1:0]   rr_ptr;
`endif

  // Unpack the flat per-requester address/length buses into one struct per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g].addr = req_araddr[g*ADDR_W +: ADDR_W];
    assign req_arr[g].len  = req_arlen[g*8 +: 8];
  end

  // Pick the next owner among the currently requesting clients.
  always_comb begin : pick_winner
    logic [GNT_W-1:0] cand;
    int               j;
    win_idx = '0;
    cand    = '0;
    j       = 0;
`ifdef AXI_ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = GNT_W'(i);
      if (req_arvalid[cand]) win_idx = cand;
    end
`else
    // Scan offsets downwards from the pointer so the nearest requester at or after rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = GNT_W'(j);
      if (req_arvalid[cand]) win_idx = cand;
    end
`endif
  end

  // Route AR ready and R valid to the owner only, and R ready back from it.
  always_comb begin : route_handshakes
    req_arready = '0;
    req_rvalid  = '0;
    rready_int  = 1'b0;
    if (arvalid_q) req_arready[grant_id] = m00_axi.arready;
    if (state == DATA) begin
      req_rvalid[grant_id] = m00_axi.rvalid;
      rready_int           = req_rready[grant_id];
    end
  end

  assign r_hs = (state == DATA) && m00_axi.rvalid && rready_int;

  // Burst FSM: grant in IDLE, present the address in ADDR, stream beats in DATA until rlast.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      ar_q      <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      beat_cnt  <= '0;
      err_resp  <= 1'b0;
      err_len   <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      if (r_hs && (m00_axi.rresp != 2'b00)) err_resp <= 1'b1;
      // rlast must land exactly on beat index arlen; either a missing or an early rlast is flagged.
      if (r_hs && (m00_axi.rlast != (beat_cnt == ar_q.len))) err_len <= 1'b1;
      case (state)
        IDLE: begin
          if (|req_arvalid) begin
            grant_id  <= win_idx;
            ar_q      <= req_arr[win_idx];
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m00_axi.arready) begin
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // Only the slave's rlast ends the burst, even when the length check disagrees.
            if (m00_axi.rlast) begin
              state  <= IDLE;
              busy_q <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
              rr_ptr <= (grant_id == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m00_axi.araddr  = ar_q.addr;
  assign m00_axi.arlen   = ar_q.len;
  assign m00_axi.arsize  = 3'b110;
  assign m00_axi.arburst = 2'b01;
  assign m00_axi.arlock  = 1'b0;
  assign m00_axi.arcache = 4'b0011;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = arvalid_q;
  assign m00_axi.rready  = rready_int;

  assign req_rdata = m00_axi.rdata;
  assign req_rlast = m00_axi.rlast;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single burst, arbitration order, R backpressure, error flags, mid-burst reset.
// Latency: stimulus driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: the bench plays both the requesters and the memory slave.
module tb_axi_rd_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;

  logic                      system_clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr;
  logic [NUM_REQ*8-1:0]      req_arlen;
  logic [NUM_REQ-1:0]        req_arvalid;
  logic [NUM_REQ-1:0]        req_arready;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_rlast;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rready;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      err_resp;
  logic                      err_len;

  int errors = 0;
  int checks = 0;
  logic [7:0] beats;
  logic       done;
  logic       rr;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m00_axi ();

  axi_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .req_araddr (req_araddr),
    .req_arlen  (req_arlen),
    .req_arvalid(req_arvalid),
    .req_arready(req_arready),
    .req_rdata  (req_rdata),
    .req_rlast  (req_rlast),
    .req_rvalid (req_rvalid),
    .req_rready (req_rready),
    .m00_axi    (m00_axi),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_resp   (err_resp),
    .err_len    (err_len)
  );

  always #5 system_clk = ~system_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_araddr      = '0;
    req_arlen       = '0;
    req_arvalid     = '0;
    req_rready      = '0;
    m00_axi.arready = 1'b0;
    m00_axi.rdata   = '0;
    m00_axi.rresp   = 2'b00;
    m00_axi.rlast   = 1'b0;
    m00_axi.rvalid  = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
    req_araddr[i*ADDR_W +: ADDR_W] = a;
    req_arlen[i*8 +: 8]            = l;
    req_arvalid[i]                 = 1'b1;
  endtask

  // From IDLE with a request pending: expect the grant one cycle later, then accept the address.
  task automatic addr_phase(input int g, input logic [31:0] a, input logic [7:0] l, input bit keep);
    tick();
    check("ar_valid",  64'(m00_axi.arvalid), 64'd1);
    check("grant_id",  64'(grant_id), 64'(g));
    check("ar_addr",   64'(m00_axi.araddr), 64'(a));
    check("ar_len",    64'(m00_axi.arlen), 64'(l));
    check("busy_addr", 64'(busy), 64'd1);
    m00_axi.arready = 1'b1;
    #1;
    check("req_arready", 64'(req_arready), 64'(1 << g));
    tick();
    m00_axi.arready = 1'b0;
    if (!keep) req_arvalid[g] = 1'b0;
    #1;
    check("ar_valid_drop", 64'(m00_axi.arvalid), 64'd0);
  endtask

  // One R beat with the owner ready; data pattern carries the beat index.
  task automatic beat(input int g, input logic [7:0] idx, input logic last, input logic [1:0] resp);
    m00_axi.rvalid      = 1'b1;
    m00_axi.rdata       = '0;
    m00_axi.rdata[15:0] = {8'hA5, idx};
    m00_axi.rlast       = last;
    m00_axi.rresp       = resp;
    req_rready[g]       = 1'b1;
    #1;
    check("req_rvalid", 64'(req_rvalid), 64'(1 << g));
    check("rdata",      req_rdata[63:0], 64'({8'hA5, idx}));
    check("rlast",      64'(req_rlast), 64'(last));
    check("m_rready",   64'(m00_axi.rready), 64'd1);
    tick();
    m00_axi.rvalid = 1'b0;
    m00_axi.rlast  = 1'b0;
    m00_axi.rresp  = 2'b00;
    req_rready[g]  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_arvalid",  64'(m00_axi.arvalid), 64'd0);
    do_reset();

    // Reset state.
    check("rst_rready",   64'(m00_axi.rready), 64'd0);
    check("rst_arready",  64'(req_arready), 64'd0);
    check("rst_rvalid",   64'(req_rvalid), 64'd0);
    check("rst_grant",    64'(grant_id), 64'd0);
    check("rst_busy",     64'(busy), 64'd0);
    check("rst_err_resp", 64'(err_resp), 64'd0);
    check("rst_err_len",  64'(err_len), 64'd0);
    check("ar_consts", 64'({m00_axi.arsize, m00_axi.arburst, m00_axi.arlock, m00_axi.arcache, m00_axi.arprot}),
          64'({3'b110, 2'b01, 1'b0, 4'b0011, 3'b000}));

    // Single requester 0, 4-beat burst, no stalls.
    set_req(0, 32'h0000_1000, 8'd3);
    #1;
    check("ar_latency", 64'(m00_axi.arvalid), 64'd0);
    addr_phase(0, 32'h0000_1000, 8'd3, 1'b0);
    for (int b = 0; b < 4; b++) beat(0, 8'(b), (b == 3), 2'b00);
    #1;
    check("single_busy",    64'(busy), 64'd0);
    check("single_err_len", 64'(err_len), 64'd0);
    check("single_rvalid",  64'(req_rvalid), 64'd0);

    // All three requesting continuously with single-beat bursts.
    do_reset();
    set_req(0, 32'h0000_0100, 8'd0);
    set_req(1, 32'h0000_0200, 8'd0);
    set_req(2, 32'h0000_0300, 8'd0);
    for (int r = 0; r < 6; r++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      addr_phase(0, 32'h0000_0100, 8'd0, 1'b1);
      beat(0, 8'(r), 1'b1, 2'b00);
`else
      addr_phase(r % 3, 32'h0000_0100 * (r % 3 + 1), 8'd0, 1'b1);
      beat(r % 3, 8'(r), 1'b1, 2'b00);
`endif
    end
`ifdef AXI_ARB_FIXED_PRIO_EN
    req_arvalid[0] = 1'b0;
    addr_phase(1, 32'h0000_0200, 8'd0, 1'b1);
    beat(1, 8'd6, 1'b1, 2'b00);
`endif
    clear_inputs();
    tick();

    // Requester 1, 8-beat burst, rready toggling 1,0,1,0.
    set_req(1, 32'h0000_3000, 8'd7);
    addr_phase(1, 32'h0000_3000, 8'd7, 1'b0);
    beats = 8'd0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      rr                  = (c % 2 == 0);
      req_rready[1]       = rr;
      m00_axi.rvalid      = 1'b1;
      m00_axi.rdata       = '0;
      m00_axi.rdata[7:0]  = beats;
      m00_axi.rlast       = (beats == 8'd7);
      #1;
      check("bp_mirror", 64'(m00_axi.rready), 64'(rr));
      check("bp_rvalid", 64'(req_rvalid), 64'b010);
      if (rr) check("bp_rdata", req_rdata[63:0], 64'(beats));
      tick();
      if (rr) begin
        beats = beats + 8'd1;
        if (beats == 8'd8) done = 1'b1;
      end
    end
    clear_inputs();
    #1;
    check("bp_beats",   64'(beats), 64'd8);
    check("bp_busy",    64'(busy), 64'd0);
    check("bp_err_len", 64'(err_len), 64'd0);

    // Early rlast on beat 2 of a 4-beat burst.
    set_req(2, 32'h0000_4000, 8'd3);
    addr_phase(2, 32'h0000_4000, 8'd3, 1'b0);
    beat(2, 8'd0, 1'b0, 2'b00);
    check("early_err_pre", 64'(err_len), 64'd0);
    beat(2, 8'd1, 1'b1, 2'b00);
    #1;
    check("early_err_len",  64'(err_len), 64'd1);
    check("early_busy",     64'(busy), 64'd0);
    check("early_err_resp", 64'(err_resp), 64'd0);

    // SLVERR on a beat, then a clean burst: both flags stay set.
    set_req(0, 32'h0000_5000, 8'd0);
    addr_phase(0, 32'h0000_5000, 8'd0, 1'b0);
    beat(0, 8'd0, 1'b1, 2'b10);
    #1;
    check("resp_err_resp", 64'(err_resp), 64'd1);
    set_req(1, 32'h0000_5100, 8'd0);
    addr_phase(1, 32'h0000_5100, 8'd0, 1'b0);
    beat(1, 8'd0, 1'b1, 2'b00);
    #1;
    check("sticky_err_resp", 64'(err_resp), 64'd1);
    check("sticky_err_len",  64'(err_len), 64'd1);

    // Asynchronous reset in DATA after the first of four beats.
    set_req(2, 32'h0000_6000, 8'd3);
    addr_phase(2, 32'h0000_6000, 8'd3, 1'b0);
    beat(2, 8'd0, 1'b0, 2'b00);
    m00_axi.rvalid = 1'b1;
    req_rready[2]  = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rready",   64'(m00_axi.rready), 64'd0);
    check("arst_rvalid",   64'(req_rvalid), 64'd0);
    check("arst_arvalid",  64'(m00_axi.arvalid), 64'd0);
    check("arst_arready",  64'(req_arready), 64'd0);
    check("arst_grant",    64'(grant_id), 64'd0);
    check("arst_busy",     64'(busy), 64'd0);
    check("arst_err_resp", 64'(err_resp), 64'd0);
    check("arst_err_len",  64'(err_len), 64'd0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    set_req(0, 32'h0000_7000, 8'd1);
    addr_phase(0, 32'h0000_7000, 8'd1, 1'b0);
    beat(0, 8'd0, 1'b0, 2'b00);
    beat(0, 8'd1, 1'b1, 2'b00);
    #1;
    check("post_rst_busy",    64'(busy), 64'd0);
    check("post_rst_err_len", 64'(err_len), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
